uart_tx_core: RTL

Serial transmitter stage of the UART, sitting directly downstream of the TX byte FIFO. It pops bytes from the FIFO's first-word-fall-through read port whenever the FIFO is non-empty. Each byte is serialised LSB-first onto `tx` as start bit, data bits, optional parity bit, and stop bit(s). The bit period comes from an internal clock-divider counter; no external baud tick is needed.

---
 rtl/uart_tx_core.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_core
// Summary  : UART serial transmitter fed from a first-word-fall-through byte
//            FIFO. Define UART_TX_PARITY_EN to add a parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_core #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done_tick
);

  localparam int unsigned c_CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned c_BW = $clog2(DATA_BITS);
  localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_BITS - 1);
  localparam logic            c_STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state, w_state_n;
  logic [c_CW-1:0]        r_clk_cnt, w_clk_cnt_n;
  logic [c_BW-1:0]        r_bit_idx, w_bit_idx_n;
  logic                   r_stop_idx, w_stop_idx_n;
  logic [DATA_BITS-1:0]   r_shreg, w_shreg_n;
  logic                   r_tx, w_tx_n;
  logic                   w_bit_end;
  logic                   w_pop_ok;
  logic                   w_pop;
  logic                   w_done;
`ifdef UART_TX_PARITY_EN
  logic                   r_par, w_par_n;
`else
  logic                   w_unused_parity_odd;
  assign w_unused_parity_odd = 1'(PARITY_ODD);
`endif

  assign w_bit_end    = (r_clk_cnt == c_CNT_LAST);
  assign fifo_rd      = w_pop;
  assign tx           = r_tx;
  assign busy         = (r_state != S_IDLE);
  assign tx_done_tick = w_done;

  always_comb begin
    w_state_n    = r_state;
    w_clk_cnt_n  = w_bit_end ? '0 : r_clk_cnt + 1'b1;
    w_bit_idx_n  = r_bit_idx;
    w_stop_idx_n = r_stop_idx;
    w_shreg_n    = r_shreg;
`ifdef UART_TX_PARITY_EN
    w_par_n      = r_par;
`endif
    w_pop_ok     = 1'b0;
    w_done       = 1'b0;
    w_tx_n       = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        w_pop_ok    = 1'b1;
        w_clk_cnt_n = '0;
      end
      S_START: begin
        if (w_bit_end) begin
          w_bit_idx_n = '0;
          w_state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shreg_n = r_shreg >> 1;
          if (r_bit_idx == c_BIT_LAST) begin
            w_stop_idx_n = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_state_n    = S_PARITY;
`else
            w_state_n    = S_STOP;
`endif
          end else begin
            w_bit_idx_n = r_bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_stop_idx_n = 1'b0;
          w_state_n    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop_idx == c_STOP_LAST) begin
            w_done    = 1'b1;
            w_pop_ok  = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_stop_idx_n = r_stop_idx + 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // Reset gating keeps the pop strobe quiet while the FSM is held in IDLE.
    w_pop = w_pop_ok & ~fifo_empty & ~reset;
    if (w_pop) begin
      w_shreg_n   = fifo_data;
`ifdef UART_TX_PARITY_EN
      w_par_n     = (^fifo_data) ^ 1'(PARITY_ODD);
`endif
      w_clk_cnt_n = '0;
      w_state_n   = S_START;
    end

    // Line level is registered from the next state so it changes on the bit edge.
    unique case (w_state_n)
      S_START:  w_tx_n = 1'b0;
      S_DATA:   w_tx_n = w_shreg_n[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_n = w_par_n;
`endif
      default:  w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shreg    <= '0;
      r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_clk_cnt  <= w_clk_cnt_n;
      r_bit_idx  <= w_bit_idx_n;
      r_stop_idx <= w_stop_idx_n;
      r_shreg    <= w_shreg_n;
      r_tx       <= w_tx_n;
`ifdef UART_TX_PARITY_EN
      r_par      <= w_par_n;
`endif
    end
  end

endmodule
`default_nettype wire
